// File: rtl/mmio_host_pkg.sv
// Shared types and constants for the MMIO host port: FSM states,
// window offsets and status-word bit positions.
package mmio_host_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned OFS_CTRL = 0;
    localparam int unsigned OFS_SIG0 = 4;

    localparam int unsigned ST_DONE     = 16;
    localparam int unsigned ST_DRAIN    = 17;
    localparam int unsigned ST_OVF      = 18;
    localparam int unsigned ST_DROP_LSB = 24;

endpackage

// File: rtl/mmio_host_port_if.sv
// dmem write/read bus plus signature stream and done flag of the MMIO host port.
interface mmio_host_port_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CH_W   = 2
);
    logic              dmem_wr_en;
    logic [ADDR_W-1:0] dmem_wr_addr;
    logic [DATA_W-1:0] dmem_wr_data;
    logic [ADDR_W-1:0] dmem_rd_addr;
    logic              mmio_wr_hit;
    logic              mmio_rd_hit;
    logic [DATA_W-1:0] mmio_rd_data;
    logic              sig_valid;
    logic              sig_ready;
    logic [DATA_W-1:0] sig_data;
    logic [CH_W-1:0]   sig_ch;
    logic              done;

    modport master (
        output dmem_wr_en, dmem_wr_addr, dmem_wr_data, dmem_rd_addr, sig_ready,
        input  mmio_wr_hit, mmio_rd_hit, mmio_rd_data, sig_valid, sig_data, sig_ch, done
    );

    modport slave (
        input  dmem_wr_en, dmem_wr_addr, dmem_wr_data, dmem_rd_addr, sig_ready,
        output mmio_wr_hit, mmio_rd_hit, mmio_rd_data, sig_valid, sig_data, sig_ch, done
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head output; pointers carry an extra
// wrap bit so full and empty are distinguished without a counter.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_wr, do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd   = pop_i && !empty_o;
    assign do_wr   = push_i && (!full_o || do_rd);
    assign data_o  = head_q;

    // The head register preloads the next entry; when that entry is the one
    // being written this cycle it must come from data_i, not the array.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
        if (rd_ptr_d == wr_ptr_d) begin
            head_d = '0;
        end else if (do_wr && (rd_ptr_d == wr_ptr_q)) begin
            head_d = data_i;
        end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/mmio_host_port.sv
// MMIO window on the dmem write bus: decodes signature-channel writes into a
// FIFO stream and a halt command that drains the FIFO and then raises done.
module mmio_host_port
    import mmio_host_pkg::*;
#(
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = ADDR_W'(32'hF000_0000),
    parameter int unsigned        NUM_CH     = 2,
    parameter int unsigned        FIFO_DEPTH = 16,
    parameter logic [DATA_W-1:0]  HALT_MAGIC = DATA_W'(32'hCAFE_CAFE)
) (
    input  logic            sysclk,
    input  logic            nrst_in,
    mmio_host_port_if.slave bus
);
    localparam int unsigned   CH_W      = $clog2(NUM_CH + 1);
    localparam int unsigned   OW        = ADDR_W - 2;
    localparam logic [OW-1:0] BASE_WORD = BASE_ADDR[ADDR_W-1:2];
    localparam logic [OW-1:0] WIN_WORDS = OW'(NUM_CH + 1);
    localparam logic [OW-1:0] CTRL_WORD = OW'(OFS_CTRL / 4);
    localparam logic [OW-1:0] SIG0_WORD = OW'(OFS_SIG0 / 4);

    state_e           state_q, state_d;
    logic [15:0]      sig_count_q, sig_count_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    logic [OW-1:0]    wr_off, rd_off;
    logic             wr_in_win, rd_in_win;
    logic             halt_wr, ch_wr, push_ok, drop, pop;
    logic [CH_W-1:0]  wr_ch;
    logic             fifo_full, fifo_empty;
    logic [CH_W+DATA_W-1:0] head;
    logic [31:0]      status;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^{bus.dmem_wr_addr[1:0], bus.dmem_rd_addr[1:0]};

    // Word offsets wrap below the base, so one unsigned compare bounds both ends.
    assign wr_off    = bus.dmem_wr_addr[ADDR_W-1:2] - BASE_WORD;
    assign rd_off    = bus.dmem_rd_addr[ADDR_W-1:2] - BASE_WORD;
    assign wr_in_win = (wr_off < WIN_WORDS);
    assign rd_in_win = (rd_off < WIN_WORDS);

    assign bus.mmio_wr_hit = bus.dmem_wr_en && wr_in_win;
    assign bus.mmio_rd_hit = rd_in_win;

    assign halt_wr = bus.mmio_wr_hit && (wr_off == CTRL_WORD) &&
                     (bus.dmem_wr_data == HALT_MAGIC);
    assign ch_wr   = bus.mmio_wr_hit && (wr_off >= SIG0_WORD) && (state_q == RUN);
    assign wr_ch   = CH_W'(wr_off - SIG0_WORD + OW'(1));
    assign pop     = !fifo_empty && bus.sig_ready;
    assign push_ok = ch_wr && (!fifo_full || pop);
    assign drop    = ch_wr && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (CH_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_ni  (nrst_in),
        .push_i  (push_ok),
        .pop_i   (bus.sig_ready),
        .data_i  ({wr_ch, bus.dmem_wr_data}),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.sig_valid = !fifo_empty;
    assign bus.sig_data  = head[DATA_W-1:0];
    assign bus.sig_ch    = head[CH_W+DATA_W-1:DATA_W];
    assign bus.done      = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt_wr) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        sig_count_d = sig_count_q;
        drop_cnt_d  = drop_cnt_q;
        overflow_d  = overflow_q;
        if (push_ok && (sig_count_q != 16'hFFFF)) begin
            sig_count_d = sig_count_q + 16'd1;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q     <= RUN;
            sig_count_q <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_count_q <= sig_count_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        status                   = '0;
        status[15:0]             = sig_count_q;
        status[ST_DONE]          = (state_q == DONE);
        status[ST_DRAIN]         = (state_q == DRAIN);
        status[ST_OVF]           = overflow_q;
        status[ST_DROP_LSB +: 8] = drop_cnt_q;
    end

    assign bus.mmio_rd_data = (rd_in_win && (rd_off == CTRL_WORD)) ? DATA_W'(status) : '0;

endmodule

// File: tb/tb_mmio_host_port.sv
// Directed bench for mmio_host_port with a scoreboard-checked signature stream.
module tb_mmio_host_port;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CH_W   = 2;
    localparam logic [31:0] BASE   = 32'hF000_0000;
    localparam logic [31:0] MAGIC  = 32'hCAFE_CAFE;

    logic sysclk  = 1'b0;
    logic nrst_in = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    logic [CH_W+DATA_W-1:0] exp_q[$];
    logic [CH_W+DATA_W-1:0] mon_exp;

    mmio_host_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH_W(CH_W)) bus();

    mmio_host_port #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE),
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (DEPTH),
        .HALT_MAGIC (MAGIC)
    ) dut (
        .sysclk  (sysclk),
        .nrst_in (nrst_in),
        .bus     (bus)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // A handshake seen at the falling edge completes at the next rising edge.
    always @(negedge sysclk) begin
        if (nrst_in && bus.sig_valid && bus.sig_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra: got ch=%0d data=0x%08h with nothing expected",
                         bus.sig_ch, bus.sig_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("stream_word", {bus.sig_ch, bus.sig_data}, mon_exp);
            end
        end
    end

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic exp_hit, input string name);
        bus.dmem_wr_en   = 1'b1;
        bus.dmem_wr_addr = addr;
        bus.dmem_wr_data = data;
        #1 check(name, bus.mmio_wr_hit, exp_hit);
        @(posedge sysclk);
        #1 bus.dmem_wr_en = 1'b0;
    endtask

    task automatic chk_status(input logic [31:0] exp, input string name);
        bus.dmem_rd_addr = BASE;
        #1 check(name, bus.mmio_rd_data, exp);
    endtask

    task automatic do_reset();
        nrst_in        = 1'b0;
        exp_q.delete();
        bus.sig_ready  = 1'b0;
        bus.dmem_wr_en = 1'b0;
        @(posedge sysclk);
        #1 nrst_in = 1'b1;
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.dmem_wr_en   = 1'b0;
        bus.dmem_wr_addr = '0;
        bus.dmem_wr_data = '0;
        bus.dmem_rd_addr = BASE;
        bus.sig_ready    = 1'b0;

        // Reset state
        #3;
        check("rst_valid", bus.sig_valid, 1'b0);
        check("rst_done",  bus.done, 1'b0);
        check("rst_data",  bus.sig_data, 32'h0);
        check("rst_ch",    bus.sig_ch, 2'd0);
        check("rst_status", bus.mmio_rd_data, 32'h0);
        @(posedge sysclk);
        #1 nrst_in = 1'b1;
        @(posedge sysclk);
        #1;

        // Channel write then halt
        bus.sig_ready = 1'b1;
        exp_q.push_back({2'd1, 32'h1234_5678});
        wr(BASE + 32'd4, 32'h1234_5678, 1'b1, "hit_sig1");
        check("latency_valid", bus.sig_valid, 1'b1);
        check("latency_ch", bus.sig_ch, 2'd1);
        wr(BASE, MAGIC, 1'b1, "hit_halt");
        check("drain_done_low", bus.done, 1'b0);
        chk_status(32'h0002_0001, "status_drain");
        @(posedge sysclk);
        #1 check("done_high", bus.done, 1'b1);
        chk_status(32'h0001_0001, "status_done");
        check("done_valid_low", bus.sig_valid, 1'b0);
        do_reset();

        // Non-window addresses, disabled strobe, non-magic control write
        wr(32'h0000_0100, 32'h55, 1'b0, "hit_low_addr");
        wr(BASE + 32'd12, 32'h66, 1'b0, "hit_ofs12");
        bus.dmem_wr_addr = BASE + 32'd4;
        bus.dmem_wr_en   = 1'b0;
        #1 check("hit_no_en", bus.mmio_wr_hit, 1'b0);
        wr(BASE, 32'h0, 1'b1, "hit_ctrl_nonmagic");
        bus.dmem_rd_addr = BASE + 32'd12;
        #1 check("rdhit_ofs12", bus.mmio_rd_hit, 1'b0);
        bus.dmem_rd_addr = BASE - 32'd4;
        #1 check("rdhit_below", bus.mmio_rd_hit, 1'b0);
        bus.dmem_rd_addr = BASE + 32'd8;
        #1 check("rdhit_ch2", bus.mmio_rd_hit, 1'b1);
        check("rddata_ch2", bus.mmio_rd_data, 32'h0);
        chk_status(32'h0000_0000, "status_untouched");
        check("nowin_valid", bus.sig_valid, 1'b0);

        // Overflow with the sink stalled; first address has nonzero low bits
        @(posedge sysclk);
        #1;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back({2'd2, 32'h100 + 32'(i)});
            wr((i == 0) ? BASE + 32'h0A : BASE + 32'd8, 32'h100 + 32'(i), 1'b1, "hit_ovf");
        end
        bus.dmem_wr_en   = 1'b1;
        bus.dmem_wr_addr = BASE + 32'd8;
        bus.dmem_wr_data = 32'h111;
        bus.dmem_rd_addr = BASE;
        #1 check("status_same_cycle", bus.mmio_rd_data, 32'h0104_0010);
        @(posedge sysclk);
        #1 bus.dmem_wr_en = 1'b0;
        chk_status(32'h0204_0010, "status_ovf");
        check("stall_valid", bus.sig_valid, 1'b1);
        check("stall_ch", bus.sig_ch, 2'd2);
        check("stall_data", bus.sig_data, 32'h100);

        // Full FIFO with a pop in the same cycle as a push
        @(posedge sysclk);
        #1 bus.sig_ready = 1'b1;
        exp_q.push_back({2'd1, 32'h0000_BEEF});
        wr(BASE + 32'd4, 32'h0000_BEEF, 1'b1, "hit_full_pop");
        bus.sig_ready = 1'b0;
        chk_status(32'h0204_0011, "status_full_pop");
        check("head_after_pop", bus.sig_data, 32'h101);
        wr(BASE + 32'd4, 32'h0000_DEAD, 1'b1, "hit_full_drop");
        chk_status(32'h0304_0011, "status_still_full");
        @(posedge sysclk);
        #1 bus.sig_ready = 1'b1;
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(posedge sysclk);
        #1 check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_valid_low", bus.sig_valid, 1'b0);
        bus.sig_ready = 1'b0;
        do_reset();

        // Halt with three words stalled; channel write in DRAIN is ignored
        exp_q.push_back({2'd1, 32'hA1});
        wr(BASE + 32'd4, 32'hA1, 1'b1, "hit_q1");
        exp_q.push_back({2'd2, 32'hA2});
        wr(BASE + 32'd8, 32'hA2, 1'b1, "hit_q2");
        exp_q.push_back({2'd1, 32'hA3});
        wr(BASE + 32'd4, 32'hA3, 1'b1, "hit_q3");
        wr(BASE, MAGIC, 1'b1, "hit_halt2");
        chk_status(32'h0002_0003, "status_drain3");
        wr(BASE + 32'd4, 32'hDEAD, 1'b1, "hit_drain_sig");
        chk_status(32'h0002_0003, "status_drain_ignored");
        check("drain_stalled_done", bus.done, 1'b0);
        bus.sig_ready = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 check("done_at_last_pop", bus.done, 1'b0);
        check("valid_after_last_pop", bus.sig_valid, 1'b0);
        @(posedge sysclk);
        #1 check("done_after_last_pop", bus.done, 1'b1);
        chk_status(32'h0001_0003, "status_done3");
        bus.sig_ready = 1'b0;
        do_reset();

        // Asynchronous reset while draining
        exp_q.push_back({2'd1, 32'hB1});
        wr(BASE + 32'd4, 32'hB1, 1'b1, "hit_r1");
        exp_q.push_back({2'd2, 32'hB2});
        wr(BASE + 32'd8, 32'hB2, 1'b1, "hit_r2");
        wr(BASE, MAGIC, 1'b1, "hit_halt3");
        chk_status(32'h0002_0002, "status_pre_reset");
        #1 nrst_in = 1'b0;
        exp_q.delete();
        #1 check("async_valid", bus.sig_valid, 1'b0);
        check("async_done", bus.done, 1'b0);
        check("async_data", bus.sig_data, 32'h0);
        check("async_ch", bus.sig_ch, 2'd0);
        check("async_status", bus.mmio_rd_data, 32'h0);
        @(posedge sysclk);
        #1 nrst_in = 1'b1;
        @(posedge sysclk);
        #1 check("post_reset_valid", bus.sig_valid, 1'b0);
        chk_status(32'h0000_0000, "post_reset_status");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_host_port.md
# mmio_host_port

Synthesizable memory-mapped host port on the core's data-memory write bus. It replaces testbench-only signature/halt decoding with a parametrised block. Writes into a small MMIO window are decoded into tagged signature words or a halt command. Signature words are buffered in a FIFO and drained over a valid/ready stream; the block reports `done` only after a halt command has been seen and the FIFO is empty. The block sits between `core` (dmem port) and the external memory/top level; `mmio_wr_hit` suppresses the memory write for window addresses.

## Interface
- `DATA_W`, 32, data width of dmem bus and signature words
- `ADDR_W`, 32, dmem address width
- `BASE_ADDR`, 32'hF000_0000, window base; word-aligned
- `NUM_CH`, 2, signature channels; channel k at `BASE_ADDR + 4*(k+1)`; range 1..7
- `FIFO_DEPTH`, 16, signature FIFO entries; power of two, ≥2
- `HALT_MAGIC`, 32'hCAFE_CAFE, value at `BASE_ADDR` that requests halt

Ports:
- `sysclk` in 1: clock, single domain
- `nrst_in` in 1: reset, asynchronous, active-low
- `dmem_wr_en` in 1: core write strobe
- `dmem_wr_addr` in ADDR_W: write address
- `dmem_wr_data` in DATA_W: write data
- `dmem_rd_addr` in ADDR_W: read address
- `mmio_wr_hit` out 1: combinational; write targets window, so external memory must not be written
- `mmio_rd_hit` out 1: combinational; `dmem_rd_addr` is in window
- `mmio_rd_data` out DATA_W: combinational; status word or 0
- `sig_valid` out 1: FIFO head valid
- `sig_ready` in 1: sink accepts head
- `sig_data` out DATA_W: head data
- `sig_ch` out $clog2(NUM_CH+1): head channel index, 1..NUM_CH
- `done` out 1: halt seen and FIFO drained; sticky

## Operation
- Window: `[BASE_ADDR, BASE_ADDR + 4*(NUM_CH+1))`. Address bits [1:0] are ignored.
- Offset 0, write: if data == `HALT_MAGIC` and state is RUN, go to DRAIN. Any other value, or any state other than RUN: hit, no effect.
- Offset 4k, write (k = 1..NUM_CH), in RUN:
  - FIFO not full, or full with a pop in the same cycle: push {k, data}; `sig_count`++ (saturates at 16'hFFFF).
  - FIFO full with no pop: word is dropped; `overflow` is set (sticky); `drop_cnt`++ (8-bit, saturating).
- Channel writes in DRAIN or DONE: hit, discarded, not counted.
- State machine (from `mmio_host_pkg`):
  - RUN → DRAIN on halt write.
  - DRAIN → DONE when FIFO is empty. Evaluated on the registered empty flag, so a halt with an empty FIFO reaches DONE 1 cycle later.
  - DONE is terminal until reset.
- Stream: pop when `sig_valid & sig_ready`. `sig_data` and `sig_ch` are held stable while `sig_valid & !sig_ready`.
- Read at offset 0: status word {`drop_cnt`[7:0], 5'b0, `overflow`, state==DRAIN, `done`, `sig_count`[15:0]}, MSB first. Read at other window offsets returns 0.
- Reset (async): state RUN, FIFO empty, counters 0, `overflow` 0. Outputs during reset: `sig_valid`=0, `done`=0, `sig_data`=0, `sig_ch`=0. Reset mid-drain discards all FIFO contents.

## Timing
- Write to head: a push into an empty FIFO gives `sig_valid`=1 on the next cycle, i.e. 1-cycle latency.
- Throughput: one push and one pop per cycle, sustained.
- Simultaneous push+pop:
  - FIFO full: both occur; occupancy unchanged.
  - FIFO empty: the push is visible next cycle; no bypass.
- `done` rises 1 cycle after the pop that empties the FIFO in DRAIN.
- Status counters update 1 cycle after the write; a same-cycle read returns the old values.
- Hit outputs are purely combinational from the address and `dmem_wr_en`. `mmio_wr_hit`=0 when `dmem_wr_en`=0.

## Structure
- `mmio_host_pkg`:
  - state enum {RUN, DRAIN, DONE}
  - offset constants `OFS_CTRL`=0, `OFS_SIG0`=4
  - status bit positions: `ST_DONE`=16, `ST_DRAIN`=17, `ST_OVF`=18, `ST_DROP_LSB`=24
- Sub-module `sync_fifo`:
  - parameters: width, depth
  - ports: push/pop/full/empty, registered output, pointer wrap via an extra MSB
- Top block contains the decode, state machine, counters and status mux.

## Test plan
- Channel write then halt: write 32'h1234_5678 to F000_0004, then CAFE_CAFE to F000_0000, `sig_ready`=1 → `sig_valid` on cycle+1 with `sig_ch`=1 and data 1234_5678; `done`=1 after the drain; `mmio_wr_hit` high on both writes.
- Overflow: hold `sig_ready`=0 and do 18 writes to F000_0008 with DEPTH=16 → 16 entries buffered; status reads `drop_cnt`=2, `overflow`=1, `sig_count`=16.
- Full with simultaneous pop: FIFO full, `sig_ready`=1, one write in the same cycle → no drop; occupancy stays 16; FIFO order preserved.
- Non-magic halt and post-halt writes: write 0 to F000_0000 → state stays RUN. Then halt with 3 words queued and stalled → state stays DRAIN; a channel write in DRAIN is not counted; `done` rises 1 cycle after the third pop.
- Reset mid-drain: assert `nrst_in`=0 asynchronously while in DRAIN → `sig_valid`=0, `done`=0 and status=0 immediately, without waiting for a clock edge.
- Non-window addresses: write to 0000_0100 or F000_000C (NUM_CH=2) → `mmio_wr_hit`=0; no push; counters unchanged.
